// File: rtl/tof_frame_builder.sv
// tof_frame_builder
//
// Collects the per-zone distance stream from the ToF sensor FSM into complete 8x8 frames.
// It uses a two-bank RAM and tracks the nearest zone of each frame. Finished frames are
// published to a downstream reader through a valid/ack handshake.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   sample_valid  one-cycle strobe, a complete zone sample is present
//   sample_index  zone number of the sample
//   sample_data   distance of the sample (mm)
//   frame_ack     reader is done with the published frame, releases the read bank
//   rd_addr       zone address into the published frame
//   rd_data       distance at rd_addr, registered (1-cycle latency)
//   frame_valid   a published frame is available and stable
//   frame_seq     sequence number of the published frame (wraps)
//   min_dist      minimum distance of the published frame
//   min_zone      zone holding min_dist
//   near_alarm    min_dist below NEAR_THRESH for the published frame
//   sample_err    one-cycle pulse on an out-of-order sample
//   drop_cnt      frames completed while the read bank was busy (saturating)
//
// Build option:
//   TOF_ZERO_SKIP_EN  zero samples (no target) are stored but do not compete for the minimum

module tof_frame_builder #(
  parameter int unsigned       ZONES       = 64,
  parameter int unsigned       IDX_W       = 6,
  parameter int unsigned       DATA_W      = 14,
  parameter logic [DATA_W-1:0] NEAR_THRESH = 14'd300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [IDX_W-1:0]  sample_index,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              frame_ack,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic [7:0]        frame_seq,
  output logic [DATA_W-1:0] min_dist,
  output logic [IDX_W-1:0]  min_zone,
  output logic              near_alarm,
  output logic              sample_err,
  output logic [7:0]        drop_cnt
);

`ifdef TOF_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LastZone = IDX_W'(ZONES - 1);
  localparam logic [IDX_W-1:0] OneIdx   = IDX_W'(1);

  typedef enum logic [0:0] {StWaitFirst, StCollect} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  expect_q, expect_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [IDX_W-1:0]  run_zone_q, run_zone_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_valid_q, frame_valid_d;
  logic [7:0]        frame_seq_q, frame_seq_d;
  logic [DATA_W-1:0] min_dist_q, min_dist_d;
  logic [IDX_W-1:0]  min_zone_q, min_zone_d;
  logic              near_alarm_q, near_alarm_d;
  logic              sample_err_q, sample_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_en;
  logic              commit;
  logic              bank_free;
  logic              is_zero;
  logic              better;
  logic [DATA_W-1:0] start_min;
  logic              rd_bank;

  logic [DATA_W-1:0] mem_q [2][ZONES];

  // A zero sample means "no target"; with zero skipping it must never win the minimum.
  assign is_zero   = ZeroSkip && (sample_data == '0);
  assign start_min = is_zero ? '1 : sample_data;
  // Strict compare keeps the lower zone on ties.
  assign better    = (sample_data < run_min_q) && !is_zero;
  assign rd_bank   = ~wr_bank_q;

  // Sample acceptance FSM
  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    run_min_d    = run_min_q;
    run_zone_d   = run_zone_q;
    wr_en        = 1'b0;
    commit       = 1'b0;
    sample_err_d = 1'b0;
    case (state_q)
      StWaitFirst: begin
        // Non-zero indices are ignored silently so the block can join mid-stream.
        if (sample_valid && sample_index == '0) begin
          wr_en      = 1'b1;
          run_min_d  = start_min;
          run_zone_d = '0;
          expect_d   = OneIdx;
          state_d    = StCollect;
        end
      end
      StCollect: begin
        if (sample_valid) begin
          if (sample_index == expect_q) begin
            wr_en = 1'b1;
            if (better) begin
              run_min_d  = sample_data;
              run_zone_d = sample_index;
            end
            if (sample_index == LastZone) begin
              commit  = 1'b1;
              state_d = StWaitFirst;
            end else begin
              expect_d = expect_q + 1'b1;
            end
          end else if (sample_index == '0) begin
            // Restart: drop the partial frame, this sample opens a new one.
            sample_err_d = 1'b1;
            wr_en        = 1'b1;
            run_min_d    = start_min;
            run_zone_d   = '0;
            expect_d     = OneIdx;
          end else begin
            sample_err_d = 1'b1;
            state_d      = StWaitFirst;
          end
        end
      end
      default: state_d = StWaitFirst;
    endcase
  end

  // Publish / handshake
  always_comb begin
    bank_free     = !frame_valid_q || frame_ack;
    wr_bank_d     = wr_bank_q;
    frame_valid_d = frame_valid_q;
    frame_seq_d   = frame_seq_q;
    min_dist_d    = min_dist_q;
    min_zone_d    = min_zone_q;
    near_alarm_d  = near_alarm_q;
    drop_cnt_d    = drop_cnt_q;
    if (commit && bank_free) begin
      // run_*_d already includes the final sample.
      wr_bank_d     = ~wr_bank_q;
      frame_valid_d = 1'b1;
      frame_seq_d   = frame_seq_q + 8'd1;
      min_dist_d    = run_min_d;
      min_zone_d    = run_zone_d;
      near_alarm_d  = run_min_d < NEAR_THRESH;
    end else begin
      if (commit && drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (frame_ack) begin
        frame_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StWaitFirst;
      expect_q      <= '0;
      run_min_q     <= '1;
      run_zone_q    <= '0;
      wr_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_seq_q   <= '0;
      min_dist_q    <= '1;
      min_zone_q    <= '0;
      near_alarm_q  <= 1'b0;
      sample_err_q  <= 1'b0;
      drop_cnt_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      expect_q      <= expect_d;
      run_min_q     <= run_min_d;
      run_zone_q    <= run_zone_d;
      wr_bank_q     <= wr_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_seq_q   <= frame_seq_d;
      min_dist_q    <= min_dist_d;
      min_zone_q    <= min_zone_d;
      near_alarm_q  <= near_alarm_d;
      sample_err_q  <= sample_err_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_data_q     <= mem_q[rd_bank][rd_addr];
    end
  end

  // Frame storage, never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      mem_q[wr_bank_q][sample_index] <= sample_data;
    end
  end

  assign rd_data     = rd_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_seq   = frame_seq_q;
  assign min_dist    = min_dist_q;
  assign min_zone    = min_zone_q;
  assign near_alarm  = near_alarm_q;
  assign sample_err  = sample_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tof_frame_builder.sv
// Directed bench for tof_frame_builder: inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that consumed them.

module tb_tof_frame_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [5:0]  sample_index;
  logic [13:0] sample_data;
  logic        frame_ack;
  logic [5:0]  rd_addr;
  logic [13:0] rd_data;
  logic        frame_valid;
  logic [7:0]  frame_seq;
  logic [13:0] min_dist;
  logic [5:0]  min_zone;
  logic        near_alarm;
  logic        sample_err;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tof_frame_builder dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_index (sample_index),
    .sample_data  (sample_data),
    .frame_ack    (frame_ack),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_valid  (frame_valid),
    .frame_seq    (frame_seq),
    .min_dist     (min_dist),
    .min_zone     (min_zone),
    .near_alarm   (near_alarm),
    .sample_err   (sample_err),
    .drop_cnt     (drop_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Data pattern for each directed frame.
  function automatic logic [13:0] frame_data(input int mode, input int i);
    case (mode)
      0:       return (i == 37) ? 14'd250 : 14'(1000 + i);
      1:       return 14'd500;
      2:       return (i == 20 || i == 50) ? 14'd700 : 14'd900;
      3:       return (i == 3 || i == 9) ? 14'd0 : 14'd800;
      default: return 14'(1000 + i);
    endcase
  endfunction

  task automatic drive_sample(input int idx, input logic [13:0] data);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_index = 6'(idx);
    sample_data  = data;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Back-to-back zones 0..63; optionally assert frame_ack with zone 63.
  task automatic send_frame(input int mode, input bit ack_last, output bit err_seen);
    err_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i > 0) err_seen |= sample_err;
      sample_valid = 1'b1;
      sample_index = 6'(i);
      sample_data  = frame_data(mode, i);
      frame_ack    = ack_last && (i == 63);
    end
    @(negedge clk);
    err_seen |= sample_err;
    sample_valid = 1'b0;
    frame_ack    = 1'b0;
  endtask

  task automatic read_zone(input int addr, output logic [13:0] val);
    @(negedge clk);
    rd_addr = 6'(addr);
    @(negedge clk);
    val = rd_data;
  endtask

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_valid"}, 32'(frame_valid), 32'd0);
    check_val({pfx, "_seq"},   32'(frame_seq),   32'd0);
    check_val({pfx, "_min"},   32'(min_dist),    32'h3FFF);
    check_val({pfx, "_zone"},  32'(min_zone),    32'd0);
    check_val({pfx, "_near"},  32'(near_alarm),  32'd0);
    check_val({pfx, "_err"},   32'(sample_err),  32'd0);
    check_val({pfx, "_drop"},  32'(drop_cnt),    32'd0);
    check_val({pfx, "_rd"},    32'(rd_data),     32'd0);
  endtask

  initial begin
    bit          err_seen;
    logic [13:0] val;

    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_index = '0;
    sample_data  = '0;
    frame_ack    = 1'b0;
    rd_addr      = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;

    // Frame 1: minimum in zone 37
    send_frame(0, 1'b0, err_seen);
    check_val("f1_valid", 32'(frame_valid), 32'd1);
    check_val("f1_seq",   32'(frame_seq),   32'd1);
    check_val("f1_min",   32'(min_dist),    32'd250);
    check_val("f1_zone",  32'(min_zone),    32'd37);
    check_val("f1_near",  32'(near_alarm),  32'd1);
    check_val("f1_err",   32'(err_seen),    32'd0);
    read_zone(5, val);
    check_val("f1_rd5", 32'(val), 32'd1005);
    read_zone(37, val);
    check_val("f1_rd37", 32'(val), 32'd250);

    // Frame 2 while bank busy: dropped
    send_frame(1, 1'b0, err_seen);
    check_val("drop_cnt",   32'(drop_cnt),    32'd1);
    check_val("drop_valid", 32'(frame_valid), 32'd1);
    check_val("drop_seq",   32'(frame_seq),   32'd1);
    check_val("drop_min",   32'(min_dist),    32'd250);
    read_zone(5, val);
    check_val("drop_rd5", 32'(val), 32'd1005);

    // Release the frame; a second ack with nothing published is ignored
    @(negedge clk) frame_ack = 1'b1;
    @(negedge clk) frame_ack = 1'b0;
    check_val("ack_clear", 32'(frame_valid), 32'd0);
    @(negedge clk) frame_ack = 1'b1;
    @(negedge clk) frame_ack = 1'b0;
    check_val("ack_idle", 32'(frame_valid), 32'd0);
    check_val("ack_seq",  32'(frame_seq),   32'd1);

    // Out-of-order: 0..10, then 12 (error), then 13 (ignored)
    for (int i = 0; i <= 10; i++) drive_sample(i, 14'd100);
    check_val("ooo_quiet", 32'(sample_err), 32'd0);
    drive_sample(12, 14'd100);
    check_val("ooo_err", 32'(sample_err), 32'd1);
    drive_sample(13, 14'd100);
    check_val("ooo_ign", 32'(sample_err), 32'd0);
    check_val("ooo_valid", 32'(frame_valid), 32'd0);

    // Full frame after the error, tie at zones 20 and 50 keeps 20
    send_frame(2, 1'b0, err_seen);
    check_val("f3_err",   32'(err_seen),    32'd0);
    check_val("f3_valid", 32'(frame_valid), 32'd1);
    check_val("f3_seq",   32'(frame_seq),   32'd2);
    check_val("f3_min",   32'(min_dist),    32'd700);
    check_val("f3_zone",  32'(min_zone),    32'd20);
    check_val("f3_near",  32'(near_alarm),  32'd0);

    // Ack coincides with zone 63: new frame published, no drop
    send_frame(3, 1'b1, err_seen);
    check_val("f4_valid", 32'(frame_valid), 32'd1);
    check_val("f4_seq",   32'(frame_seq),   32'd3);
    check_val("f4_drop",  32'(drop_cnt),    32'd1);
`ifdef TOF_ZERO_SKIP_EN
    check_val("f4_min",  32'(min_dist),   32'd800);
    check_val("f4_zone", 32'(min_zone),   32'd0);
    check_val("f4_near", 32'(near_alarm), 32'd0);
`else
    check_val("f4_min",  32'(min_dist),   32'd0);
    check_val("f4_zone", 32'(min_zone),   32'd3);
    check_val("f4_near", 32'(near_alarm), 32'd1);
`endif
    read_zone(9, val);
    check_val("f4_rd9", 32'(val), 32'd0);
    read_zone(4, val);
    check_val("f4_rd4", 32'(val), 32'd800);

    // Reset at zone 40 aborts the frame and clears published state
    for (int i = 0; i < 40; i++) drive_sample(i, 14'd50);
    @(negedge clk);
    reset        = 1'b0;
    sample_valid = 1'b1;
    sample_index = 6'd40;
    sample_data  = 14'd50;
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    check_reset_state("mrst");

    send_frame(4, 1'b0, err_seen);
    check_val("f5_valid", 32'(frame_valid), 32'd1);
    check_val("f5_seq",   32'(frame_seq),   32'd1);
    check_val("f5_min",   32'(min_dist),    32'd1000);
    check_val("f5_zone",  32'(min_zone),    32'd0);
    check_val("f5_near",  32'(near_alarm),  32'd0);
    check_val("f5_drop",  32'(drop_cnt),    32'd0);
    read_zone(63, val);
    check_val("f5_rd63", 32'(val), 32'd1063);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
